// File: rtl/core_pkg.sv
// Shared RV32I decode constants and the id->exe bus layout used by idu and exu.
package core_pkg;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4;
    localparam logic [2:0] F3_BGE = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_SLL = 3'd1, F3_SR = 3'd5;

    localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_AND = 4, ALU_OR = 5;
    localparam int ALU_XOR = 6, ALU_SLL = 7, ALU_SRL = 8, ALU_SRA = 9, ALU_LUI = 10;
    localparam int ALU_OP_W = 11;

    localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4, LD_LHU = 3'd5;
    localparam logic [3:0] SM_NONE = 4'b0000, SM_SB = 4'b0001, SM_SH = 4'b0011, SM_SW = 4'b1111;

    localparam int BUS_W = 120;
    localparam int BUS_ALUOP_LSB = 109, BUS_SRC1_LSB = 77, BUS_SRC2_LSB = 45, BUS_DREGW = 44;
    localparam int BUS_DADDR_LSB = 39, BUS_LOAD_LSB = 36, BUS_SMASK_LSB = 32, BUS_SDATA_LSB = 0;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [31:0]         src1;
        logic [31:0]         src2;
        logic                d_regw;
        logic [4:0]          d_regaddr;
        logic [2:0]          load_inst;
        logic [3:0]          store_mask;
        logic [31:0]         store_data;
    } id_exe_bus_t;

    // alt selects sub/sra (funct7[5])
    function automatic logic [ALU_OP_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [ALU_OP_W-1:0] op;
        op = '0;
        case (f3)
            3'd0: op[alt ? ALU_SUB : ALU_ADD] = 1'b1;
            3'd1: op[ALU_SLL] = 1'b1;
            3'd2: op[ALU_SLT] = 1'b1;
            3'd3: op[ALU_SLTU] = 1'b1;
            3'd4: op[ALU_XOR] = 1'b1;
            3'd5: op[alt ? ALU_SRA : ALU_SRL] = 1'b1;
            3'd6: op[ALU_OR] = 1'b1;
            default: op[ALU_AND] = 1'b1;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] ld_code(input logic [2:0] f3);
        case (f3)
            3'd0: return LD_LB;
            3'd1: return LD_LH;
            3'd2: return LD_LW;
            3'd4: return LD_LBU;
            3'd5: return LD_LHU;
            default: return LD_NONE;
        endcase
    endfunction

    function automatic logic [3:0] st_mask(input logic [2:0] f3);
        case (f3)
            3'd0: return SM_SB;
            3'd1: return SM_SH;
            3'd2: return SM_SW;
            default: return SM_NONE;
        endcase
    endfunction
endpackage

// File: rtl/idu_regfile.sv
// Architectural register file: two async reads, one sync write, write-through, x0 = 0.
module idu_regfile #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic [REG_ADDR_WIDTH-1:0] raddr1,
    input  logic [REG_ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2,
    input  logic                      we,
    input  logic [REG_ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]     wdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**REG_ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we && waddr != '0) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : mem_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : mem_q[raddr2];
    end
endmodule

// File: rtl/idu.sv
// RV32I decode stage: pipeline register, regfile read, scoreboard stall,
// branch/jump resolution with a registered redirect, and ebreak halt.
module idu
    import core_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_to_id_valid,
    output logic                      id_to_if_ready,
    input  logic [63:0]               if_to_id_bus,
    output logic                      id_to_exe_valid,
    input  logic                      exe_to_id_ready,
    output logic [BUS_W-1:0]          id_to_exe_bus,
    input  logic                      wb_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      redirect_valid,
    output logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      halt
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic                  id_valid_q, id_valid_d, redirect_valid_q, redirect_valid_d, halt_q, halt_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, redirect_pc_q, redirect_pc_d;
    logic [31:0]           inst_q, inst_d;
    logic [NREG-1:0]       busy_q, busy_d;

    logic [4:0]            rs1, rs2, rd;
    logic [2:0]            f3;
    logic [31:0]           rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_u, imm_j, tgt;
    logic                  use_rs1, use_rs2, is_ebreak, take, br_taken, stall, fire, accept;
    id_exe_bus_t           bus_s;

    assign rs1   = inst_q[19:15];
    assign rs2   = inst_q[24:20];
    assign rd    = inst_q[11:7];
    assign f3    = inst_q[14:12];
    assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u = {inst_q[31:12], 12'b0};
    assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    idu_regfile #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rf (
        .clk(clk), .raddr1(rs1), .raddr2(rs2), .rdata1(rs1_v), .rdata2(rs2_v),
        .we(wb_we), .waddr(wb_addr), .wdata(wb_data)
    );

    always_comb begin
        case (f3)
            F3_BEQ:  br_taken = (rs1_v == rs2_v);
            F3_BNE:  br_taken = (rs1_v != rs2_v);
            F3_BLT:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
            F3_BGE:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
            F3_BLTU: br_taken = (rs1_v < rs2_v);
            F3_BGEU: br_taken = (rs1_v >= rs2_v);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        bus_s = '0; use_rs1 = 1'b0; use_rs2 = 1'b0; is_ebreak = 1'b0; take = 1'b0; tgt = '0;
        case (inst_q[6:0])
            OP_REG: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                bus_s.alu_op = alu_sel(f3, inst_q[30]);
                bus_s.src1 = rs1_v; bus_s.src2 = rs2_v; bus_s.d_regw = 1'b1;
            end
            OP_IMM: begin
                use_rs1 = 1'b1;
                bus_s.alu_op = alu_sel(f3, inst_q[30] && f3 == F3_SR);
                bus_s.src1 = rs1_v; bus_s.d_regw = 1'b1;
                bus_s.src2 = (f3 == F3_SLL || f3 == F3_SR) ? {27'b0, inst_q[24:20]} : imm_i;
            end
            OP_LUI: begin
                bus_s.alu_op[ALU_LUI] = 1'b1; bus_s.src2 = imm_u; bus_s.d_regw = 1'b1;
            end
            OP_AUIPC: begin
                bus_s.alu_op[ALU_ADD] = 1'b1; bus_s.src1 = pc_q; bus_s.src2 = imm_u; bus_s.d_regw = 1'b1;
            end
            OP_JAL, OP_JALR: begin
                use_rs1 = (inst_q[6:0] == OP_JALR);
                bus_s.alu_op[ALU_ADD] = 1'b1; bus_s.src1 = pc_q; bus_s.src2 = 32'd4; bus_s.d_regw = 1'b1;
                take = 1'b1;
                tgt  = use_rs1 ? ((rs1_v + imm_i) & ~32'd1) : (pc_q + imm_j);
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                bus_s.alu_op[ALU_ADD] = 1'b1;
                take = br_taken; tgt = pc_q + imm_b;
            end
            OP_LOAD: if (ld_code(f3) != LD_NONE) begin
                use_rs1 = 1'b1;
                bus_s.alu_op[ALU_ADD] = 1'b1; bus_s.src1 = rs1_v; bus_s.src2 = imm_i;
                bus_s.d_regw = 1'b1; bus_s.load_inst = ld_code(f3);
            end
            OP_STORE: if (st_mask(f3) != SM_NONE) begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                bus_s.alu_op[ALU_ADD] = 1'b1; bus_s.src1 = rs1_v; bus_s.src2 = imm_s;
                bus_s.store_mask = st_mask(f3); bus_s.store_data = rs2_v;
            end
            default: is_ebreak = (inst_q == INST_EBREAK);
        endcase
        if (rd == 5'd0) bus_s.d_regw = 1'b0;
        bus_s.d_regaddr = bus_s.d_regw ? rd : 5'd0;
    end

    // A writeback to the blocking register in this cycle resolves the hazard via the bypass.
    always_comb begin
        stall = id_valid_q & (
              (use_rs1      & busy_q[rs1] & ~(wb_we && wb_addr == rs1))
            | (use_rs2      & busy_q[rs2] & ~(wb_we && wb_addr == rs2))
            | (bus_s.d_regw & busy_q[rd]  & ~(wb_we && wb_addr == rd)));
    end

    // The instruction latched alongside a redirecting one is wrong-path; it is dropped.
    assign id_to_exe_valid = id_valid_q & ~stall & ~halt_q & ~is_ebreak & ~redirect_valid_q;
    assign fire            = id_to_exe_valid & exe_to_id_ready;
    assign id_to_if_ready  = (~id_valid_q | fire) & ~redirect_valid_q;
    assign accept          = if_to_id_valid & id_to_if_ready;
    assign id_to_exe_bus   = id_valid_q ? bus_s : '0;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign halt            = halt_q;

    always_comb begin
        id_valid_d = id_valid_q; pc_d = pc_q; inst_d = inst_q;
        if (accept) begin
            id_valid_d = 1'b1; pc_d = if_to_id_bus[63:32]; inst_d = if_to_id_bus[31:0];
        end else if (fire || redirect_valid_q) begin
            id_valid_d = 1'b0;
        end
        busy_d = busy_q;
        if (wb_we) busy_d[wb_addr] = 1'b0;
        if (fire && bus_s.d_regw) busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
        redirect_valid_d = fire & take;
        redirect_pc_d    = (fire & take) ? tgt : redirect_pc_q;
        halt_d           = halt_q | (id_valid_q & is_ebreak & ~redirect_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q <= 1'b0; pc_q <= '0; inst_q <= '0; busy_q <= '0;
            redirect_valid_q <= 1'b0; redirect_pc_q <= '0; halt_q <= 1'b0;
        end else begin
            id_valid_q <= id_valid_d; pc_q <= pc_d; inst_q <= inst_d; busy_q <= busy_d;
            redirect_valid_q <= redirect_valid_d; redirect_pc_q <= redirect_pc_d; halt_q <= halt_d;
        end
    end
endmodule

// File: tb/tb_idu.sv
// Directed bench for idu: decode fields, hazard stall/bypass, redirect, backpressure, halt, reset.
module tb_idu;
    logic         clk = 1'b0, rst = 1'b1;
    logic         if_to_id_valid = 1'b0, id_to_if_ready, id_to_exe_valid, exe_to_id_ready = 1'b1;
    logic [63:0]  if_to_id_bus = '0;
    logic [119:0] id_to_exe_bus, b0;
    logic         wb_we = 1'b0;
    logic [4:0]   wb_addr = '0;
    logic [31:0]  wb_data = '0;
    logic         redirect_valid, halt;
    logic [31:0]  redirect_pc;
    int           n_chk = 0, n_err = 0;

    idu dut (
        .clk(clk), .rst(rst), .if_to_id_valid(if_to_id_valid), .id_to_if_ready(id_to_if_ready),
        .if_to_id_bus(if_to_id_bus), .id_to_exe_valid(id_to_exe_valid), .exe_to_id_ready(exe_to_id_ready),
        .id_to_exe_bus(id_to_exe_bus), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] f_aluop(input logic [119:0] b); return b[119:109]; endfunction
    function automatic logic [31:0] f_src1(input logic [119:0] b);  return b[108:77];  endfunction
    function automatic logic [31:0] f_src2(input logic [119:0] b);  return b[76:45];   endfunction
    function automatic logic        f_dregw(input logic [119:0] b); return b[44];      endfunction
    function automatic logic [4:0]  f_daddr(input logic [119:0] b); return b[43:39];   endfunction
    function automatic logic [2:0]  f_load(input logic [119:0] b);  return b[38:36];   endfunction
    function automatic logic [3:0]  f_smask(input logic [119:0] b); return b[35:32];   endfunction
    function automatic logic [31:0] f_sdata(input logic [119:0] b); return b[31:0];    endfunction

    // Called at posedge+1; returns at posedge+1 with the instruction latched.
    task automatic send(input logic [31:0] pc, input logic [31:0] inst);
        int n = 0;
        if_to_id_valid = 1'b1; if_to_id_bus = {pc, inst};
        while (!id_to_if_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        if_to_id_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_we = 1'b0;
    endtask

    task automatic step; @(posedge clk); #1; endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; #1;
        chk("rst_exe_valid", id_to_exe_valid, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_halt", halt, 0);
        chk("rst_bus", id_to_exe_bus, 0);

        wb_write(5'd3, 32'h8000_0101);
        wb_write(5'd5, 32'h1234_ABCD);
        wb_write(5'd6, 32'h0000_0100);

        // addi x1,x0,5
        send(32'h8000_0000, 32'h0050_0093); #1;
        chk("addi_valid", id_to_exe_valid, 1);
        chk("addi_aluop", f_aluop(id_to_exe_bus), 11'h001);
        chk("addi_src1", f_src1(id_to_exe_bus), 0);
        chk("addi_src2", f_src2(id_to_exe_bus), 5);
        chk("addi_dregw", f_dregw(id_to_exe_bus), 1);
        chk("addi_daddr", f_daddr(id_to_exe_bus), 1);
        step;
        chk("addi_gone", id_to_exe_valid, 0);

        // add x2,x1,x1 blocks on busy x1 until writeback
        send(32'h8000_0004, 32'h0010_8133); #1;
        chk("add_stall0", id_to_exe_valid, 0);
        step;
        chk("add_stall1", id_to_exe_valid, 0);
        chk("add_stall_ready", id_to_if_ready, 0);
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd5; #1;
        chk("add_bypass_valid", id_to_exe_valid, 1);
        chk("add_bypass_src1", f_src1(id_to_exe_bus), 5);
        chk("add_bypass_src2", f_src2(id_to_exe_bus), 5);
        step;
        wb_we = 1'b0;
        wb_write(5'd2, 32'd10);

        // beq x0,x0,+16 taken
        send(32'h8000_0010, 32'h0000_0863); #1;
        chk("beq_valid", id_to_exe_valid, 1);
        chk("beq_src", {f_aluop(id_to_exe_bus), f_src1(id_to_exe_bus), f_src2(id_to_exe_bus)}, {11'h001, 64'd0});
        chk("beq_dregw", f_dregw(id_to_exe_bus), 0);
        step;
        chk("beq_redirect", redirect_valid, 1);
        chk("beq_redirect_pc", redirect_pc, 32'h8000_0020);
        chk("beq_ready_blocked", id_to_if_ready, 0);
        step;
        chk("beq_pulse_end", redirect_valid, 0);
        chk("beq_ready_back", id_to_if_ready, 1);

        // bne x0,x0 not taken
        send(32'h8000_0014, 32'h0000_1863); #1;
        chk("bne_valid", id_to_exe_valid, 1);
        step;
        chk("bne_no_redirect", redirect_valid, 0);

        // jalr x1,8(x3)
        send(32'h8000_0020, 32'h0081_80E7); #1;
        chk("jalr_src1", f_src1(id_to_exe_bus), 32'h8000_0020);
        chk("jalr_src2", f_src2(id_to_exe_bus), 4);
        chk("jalr_dregw", {f_dregw(id_to_exe_bus), f_daddr(id_to_exe_bus)}, {1'b1, 5'd1});
        step;
        chk("jalr_redirect", redirect_valid, 1);
        chk("jalr_redirect_pc", redirect_pc, 32'h8000_0108);
        wb_write(5'd1, 32'd0);

        // sh x5,2(x6)
        send(32'h8000_0030, 32'h0053_1123); #1;
        chk("sh_mask", f_smask(id_to_exe_bus), 4'b0011);
        chk("sh_data", f_sdata(id_to_exe_bus), 32'h1234_ABCD);
        chk("sh_src1", f_src1(id_to_exe_bus), 32'h100);
        chk("sh_src2", f_src2(id_to_exe_bus), 2);
        chk("sh_dregw", f_dregw(id_to_exe_bus), 0);

        // lui x4,0x12345 (sh fires on the accepting edge)
        send(32'h8000_0034, 32'h1234_5237); #1;
        chk("lui_aluop", f_aluop(id_to_exe_bus), 11'h400);
        chk("lui_src2", f_src2(id_to_exe_bus), 32'h1234_5000);

        // lhu x7,0(x6), then hold exu off for 3 cycles
        send(32'h8000_0038, 32'h0003_5383);
        exe_to_id_ready = 1'b0;
        if_to_id_valid = 1'b1; if_to_id_bus = {32'h8000_003C, 32'h0010_0073}; #1;
        chk("lhu_load", f_load(id_to_exe_bus), 3'd5);
        chk("lhu_daddr", f_daddr(id_to_exe_bus), 7);
        chk("lhu_valid", id_to_exe_valid, 1);
        b0 = id_to_exe_bus;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("bp_bus_stable", id_to_exe_bus, b0);
            chk("bp_ready", id_to_if_ready, 0);
        end
        exe_to_id_ready = 1'b1;
        step;
        if_to_id_valid = 1'b0; #1;
        chk("ebreak_not_fwd", id_to_exe_valid, 0);
        chk("ebreak_halt_pre", halt, 0);
        step;
        chk("ebreak_halt", halt, 1);
        chk("ebreak_still_held", id_to_exe_valid, 0);
        step;
        chk("halt_sticky", halt, 1);

        rst = 1'b1; step; rst = 1'b0; #1;
        chk("rst2_halt", halt, 0);
        chk("rst2_valid", id_to_exe_valid, 0);

        // rst while add x2,x1,x1 stalls on addi x1
        send(32'h8000_0000, 32'h0050_0093);
        send(32'h8000_0004, 32'h0010_8133); #1;
        chk("stall2", id_to_exe_valid, 0);
        rst = 1'b1; step; rst = 1'b0; #1;
        chk("rst3_valid", id_to_exe_valid, 0);
        chk("rst3_redirect", redirect_valid, 0);
        send(32'h8000_0004, 32'h0010_8133); #1;
        chk("rst3_busy_cleared", id_to_exe_valid, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
